// File: rtl/sigma0_inverter.sv
// Iterative SHA-256 Sigma0 engine: one Sigma0 step per RUN cycle, 1 step forward or 31 steps inverse.
// Sigma0^32 is the identity, so 31 forward steps undo a single forward step exactly.

module rotr #(
   parameter int W = 32,
   parameter int K = 1
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);
   assign y = (x >> K) | (x << (W - K));
endmodule

module sigma0_inverter (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_reg;
   logic [31:0] acc_reg;
   logic [4:0]  cnt_reg;
   logic        mode_reg;
   logic        in_ready_reg;
   logic        out_valid_reg;
   logic        busy_reg;

   logic [31:0] rot_out [3];
   logic [31:0] sigma_next;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_rot
         rotr #(
            .W (32),
            .K ((gi == 0) ? 2 : ((gi == 1) ? 13 : 22))
         ) u_rotr (
            .x (acc_reg),
            .y (rot_out[gi])
         );
      end
   endgenerate

   assign sigma_next = rot_out[0] ^ rot_out[1] ^ rot_out[2];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         acc_reg       <= 32'h0000_0000;
         cnt_reg       <= 5'd0;
         mode_reg      <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  acc_reg      <= in_data;
                  cnt_reg      <= in_mode ? 5'd30 : 5'd0;
                  mode_reg     <= in_mode;
                  state_reg    <= RUN;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
               end
            end
            RUN: begin
               acc_reg <= sigma_next;
               // A forward request is always a single step, whatever the count holds.
               if (cnt_reg == 5'd0 || !mode_reg) begin
                  state_reg     <= DONE;
                  busy_reg      <= 1'b0;
                  out_valid_reg <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - 5'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign busy      = busy_reg;
   assign out_data  = acc_reg;
endmodule

// File: tb/tb_sigma0_inverter.sv
// Bench for sigma0_inverter: timing/result model checked every cycle plus directed vectors.

module tb_sigma0_inverter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'h0;
   logic        in_mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        busy;

   int total = 0;
   int bad = 0;

   sigma0_inverter dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ror(input logic [31:0] x, input int k);
      logic [63:0] d;
      d = {x, x} >> k;
      return d[31:0];
   endfunction

   function automatic logic [31:0] sig(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] inv(input logic [31:0] x);
      logic [31:0] v;
      v = x;
      for (int i = 0; i < 31; i++) v = sig(v);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model: one request in flight, result due N edges after the accepting edge.
   int          cyc = 0;
   bit          m_active = 0;
   bit          m_known = 1;
   int          m_due = 0;
   logic [31:0] m_res = 32'h0;
   logic [31:0] m_exp = 32'h0;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_active = 0;
         m_known  = 1;
         m_exp    = 32'h0;
      end else if (!m_active) begin
         if (in_valid) begin
            m_active = 1;
            m_known  = 0;
            m_due    = cyc + (in_mode ? 31 : 1);
            m_res    = in_mode ? inv(in_data) : sig(in_data);
         end
      end else if (cyc - 1 >= m_due && out_ready) begin
         m_active = 0;
         m_known  = 1;
         m_exp    = m_res;
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         check("cyc_in_ready",  {31'b0, in_ready},  {31'b0, !m_active});
         check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_active && cyc >= m_due});
         check("cyc_busy",      {31'b0, busy},      {31'b0, m_active && cyc < m_due});
         if (m_active && cyc >= m_due) check("cyc_out_data", out_data, m_res);
         else if (m_known)             check("cyc_hold_data", out_data, m_exp);
      end
   end

   task automatic xfer(input logic [31:0] d, input logic m,
                       output logic [31:0] r, output int lat, output int bcnt);
      bit found;
      @(posedge clk); #2;
      in_valid = 1'b1; in_data = d; in_mode = m;
      @(posedge clk); #2;
      in_valid = 1'b0; in_data = $urandom; in_mode = 1'($urandom);
      bcnt = busy ? 1 : 0;
      lat = 0;
      r = 32'hx;
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) begin
            r = out_data;
            found = 1;
         end else if (busy) begin
            bcnt++;
         end
      end
      check("xfer_timeout", {31'b0, found}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, f, g, h, w, held;
      logic [31:0] fixv [2];
      int lat, bcnt;

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  {31'b0, in_ready},  32'd1);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_busy",      {31'b0, busy},      32'd0);
      check("rst_out_data",  out_data,           32'h0000_0000);
      #1 reset = 1'b0;

      check("model_sig_one", sig(32'h0000_0001), 32'h4008_0400);
      check("model_inv_one", inv(32'h4008_0400), 32'h0000_0001);

      xfer(32'h0000_0001, 1'b0, r, lat, bcnt);
      $display("fwd 00000001 -> %h lat=%0d busy=%0d", r, lat, bcnt);
      check("fwd_data", r, 32'h4008_0400);
      check("fwd_lat", lat, 32'd1);
      check("fwd_busy", bcnt, 32'd1);

      xfer(32'h4008_0400, 1'b1, r, lat, bcnt);
      $display("inv 40080400 -> %h lat=%0d busy=%0d", r, lat, bcnt);
      check("inv_data", r, 32'h0000_0001);
      check("inv_lat", lat, 32'd31);
      check("inv_busy", bcnt, 32'd31);

      fixv[0] = 32'h0000_0000;
      fixv[1] = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         for (int m = 0; m < 2; m++) begin
            xfer(fixv[i], 1'(m), r, lat, bcnt);
            $display("fixed %h mode=%0d -> %h", fixv[i], m, r);
            check("fixed_point", r, fixv[i]);
         end
      end

      for (int i = 0; i < 400; i++) begin
         w = $urandom;
         xfer(w, 1'b0, f, lat, bcnt);
         check("rt_fwd_model", f, sig(w));
         xfer(f, 1'b1, g, lat, bcnt);
         check("rt_fwd_inv", g, w);
         xfer(w, 1'b1, h, lat, bcnt);
         xfer(h, 1'b0, r, lat, bcnt);
         check("rt_inv_fwd", r, w);
         $display("roundtrip %h fwd=%h inv=%h", w, f, h);
      end

      // Backpressure: DONE held while inputs churn.
      @(posedge clk); #2;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1234_5678; in_mode = 1'b0;
      @(posedge clk); #2;
      in_valid = 1'b0;
      @(posedge clk); #1;
      held = out_data;
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_data", held, sig(32'h1234_5678));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2;
         in_valid = ~in_valid; in_data = $urandom; in_mode = 1'($urandom);
         #1;
         check("bp_hold_data", out_data, held);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
         check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      end
      @(posedge clk); #2;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_ready", {31'b0, in_ready}, 32'd1);
      check("bp_release_valid", {31'b0, out_valid}, 32'd0);
      $display("backpressure held %h", held);

      // Reset at iteration 15 of an inverse run.
      @(posedge clk); #2;
      in_valid = 1'b1; in_data = 32'h4008_0400; in_mode = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (14) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("abort_in_ready", {31'b0, in_ready}, 32'd1);
      check("abort_out_data", out_data, 32'h0000_0000);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         check("abort_no_valid", {31'b0, out_valid}, 32'd0);
      end
      $display("abort mid-run done");

      // Request coincident with reset is dropped.
      @(posedge clk); #2;
      reset = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0005; in_mode = 1'b0;
      @(posedge clk); #2;
      reset = 1'b0; in_valid = 1'b0;
      #1;
      check("rstreq_in_ready", {31'b0, in_ready}, 32'd1);
      check("rstreq_busy", {31'b0, busy}, 32'd0);
      $display("request during reset dropped");

      // Reset wins over out_ready in DONE.
      @(posedge clk); #2;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_mode = 1'b0;
      @(posedge clk); #2;
      in_valid = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1; out_ready = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("rstdone_valid", {31'b0, out_valid}, 32'd0);
      check("rstdone_ready", {31'b0, in_ready}, 32'd1);
      check("rstdone_data", out_data, 32'h0000_0000);
      $display("reset in DONE done");

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
